// File: rtl/mastermind_score_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_score_ctrl_if
//  Description : Request/result bundle between the game FSM (master) and the
//                Mastermind scoring controller (slave). The attempt-limit
//                signals exist only when MM_ATTEMPT_LIMIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mastermind_score_ctrl_if;
  logic        start_i;
  logic [11:0] guess_i;
  logic [11:0] secret_i;
  logic [2:0]  exactNum_o;
  logic [2:0]  colorNum_o;
  logic        busy_o;
  logic        done_o;
  logic        win_o;
  logic        err_o;
`ifdef MM_ATTEMPT_LIMIT_EN
  logic [2:0]  attemptsLeft_o;
  logic        gameOver_o;
`endif

  modport master (
    output start_i, guess_i, secret_i,
    input  exactNum_o, colorNum_o, busy_o, done_o, win_o, err_o
`ifdef MM_ATTEMPT_LIMIT_EN
    , input attemptsLeft_o, gameOver_o
`endif
  );

  modport slave (
    input  start_i, guess_i, secret_i,
    output exactNum_o, colorNum_o, busy_o, done_o, win_o, err_o
`ifdef MM_ATTEMPT_LIMIT_EN
    , output attemptsLeft_o, gameOver_o
`endif
  );
endinterface : mastermind_score_ctrl_if
`default_nettype wire

// File: rtl/mastermind_score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_score_ctrl
//  Description : Sequential Mastermind scorer. Latches guess/secret on start,
//                counts exact matches one position per cycle, then sums
//                min(countG, countS) one colour per cycle, and publishes
//                black/white counts (3'b111 = display off) with status.
//                Optional attempt limiting is enabled by MM_ATTEMPT_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mastermind_score_ctrl #(
  parameter int NUM_COLORS   = 6
`ifdef MM_ATTEMPT_LIMIT_EN
  , parameter int MAX_ATTEMPTS = 4
`endif
) (
  input  logic                     clk,
  input  logic                     Reset,
  mastermind_score_ctrl_if.slave   bus
);

  localparam logic [3:0] COLOR_LIMIT = 4'(NUM_COLORS);
  localparam logic [2:0] LAST_COLOR  = 3'(NUM_COLORS - 1);
  localparam logic [2:0] DISP_OFF    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXACT = 3'd1,
    S_COLOR = 3'd2,
    S_FINAL = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t      state_q,  state_d;
  logic [11:0] guess_q,  guess_d;
  logic [11:0] secret_q, secret_d;
  logic        inv_q,    inv_d;
  logic [2:0]  black_q,  black_d;
  logic [2:0]  min_q,    min_d;
  logic [2:0]  idx_q,    idx_d;
  logic [2:0]  exact_q,  exact_d;
  logic [2:0]  color_q,  color_d;
  logic        win_q,    win_d;
  logic        err_q,    err_d;
  logic        done_q,   done_d;
`ifdef MM_ATTEMPT_LIMIT_EN
  logic [2:0]  attempts_q, attempts_d;
  logic        game_over;
`endif

  // Per-digit views of the latched operands and of the live inputs
  logic [2:0] g_dig  [4];
  logic [2:0] s_dig  [4];
  logic [3:0] in_bad;
  logic       inv_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign g_dig[gi]  = guess_q[3*gi +: 3];
      assign s_dig[gi]  = secret_q[3*gi +: 3];
      assign in_bad[gi] = ({1'b0, bus.guess_i[3*gi +: 3]}  >= COLOR_LIMIT) ||
                          ({1'b0, bus.secret_i[3*gi +: 3]} >= COLOR_LIMIT);
    end
  endgenerate

  assign inv_in = |in_bad;

  // Position match for the exact pass, indexed by the low bits of idx
  logic eq_now;
  assign eq_now = (g_dig[idx_q[1:0]] == s_dig[idx_q[1:0]]);

  // Occurrences of colour idx in each operand; the smaller one is credited
  logic [2:0] cnt_g, cnt_s, cnt_min;
  always_comb begin
    cnt_g = '0;
    cnt_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (g_dig[i] == idx_q) cnt_g = cnt_g + 3'd1;
      if (s_dig[i] == idx_q) cnt_s = cnt_s + 3'd1;
    end
    cnt_min = (cnt_g < cnt_s) ? cnt_g : cnt_s;
  end

  // A new score may only begin when the controller is not busy
  logic start_ok;
  always_comb begin
    start_ok = bus.start_i && ((state_q == S_IDLE) || (state_q == S_SHOW));
`ifdef MM_ATTEMPT_LIMIT_EN
    if (game_over) start_ok = 1'b0;
`endif
  end

`ifdef MM_ATTEMPT_LIMIT_EN
  // Game ends on a win or once all attempts are used
  assign game_over = win_q || (attempts_q == 3'd0);
`endif

  // Next-state and datapath updates for the scoring sequence
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    secret_d = secret_q;
    inv_d    = inv_q;
    black_d  = black_q;
    min_d    = min_q;
    idx_d    = idx_q;
    exact_d  = exact_q;
    color_d  = color_q;
    win_d    = win_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef MM_ATTEMPT_LIMIT_EN
    attempts_d = attempts_q;
`endif
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (start_ok) begin
          guess_d  = bus.guess_i;
          secret_d = bus.secret_i;
          inv_d    = inv_in;
          black_d  = '0;
          min_d    = '0;
          idx_d    = '0;
          state_d  = S_EXACT;
        end
      end
      S_EXACT: begin
        black_d = black_q + {2'b00, eq_now};
        if (idx_q == 3'd3) begin
          idx_d   = '0;
          state_d = S_COLOR;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_COLOR: begin
        min_d = min_q + cnt_min;
        if (idx_q == LAST_COLOR) begin
          state_d = S_FINAL;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_FINAL: begin
        // minAcc never falls below blackAcc, so the subtraction cannot wrap
        if (!inv_q) begin
          exact_d = black_q;
          color_d = min_q - black_q;
          win_d   = (black_q == 3'd4);
          err_d   = 1'b0;
`ifdef MM_ATTEMPT_LIMIT_EN
          if (attempts_q != 3'd0) attempts_d = attempts_q - 3'd1;
`endif
        end else begin
          exact_d = DISP_OFF;
          color_d = DISP_OFF;
          win_d   = 1'b0;
          err_d   = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_SHOW;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset blanks the display and aborts scoring
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      secret_q <= '0;
      inv_q    <= 1'b0;
      black_q  <= '0;
      min_q    <= '0;
      idx_q    <= '0;
      exact_q  <= DISP_OFF;
      color_q  <= DISP_OFF;
      win_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef MM_ATTEMPT_LIMIT_EN
      attempts_q <= 3'(MAX_ATTEMPTS);
`endif
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      secret_q <= secret_d;
      inv_q    <= inv_d;
      black_q  <= black_d;
      min_q    <= min_d;
      idx_q    <= idx_d;
      exact_q  <= exact_d;
      color_q  <= color_d;
      win_q    <= win_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef MM_ATTEMPT_LIMIT_EN
      attempts_q <= attempts_d;
`endif
    end
  end

  assign bus.exactNum_o = exact_q;
  assign bus.colorNum_o = color_q;
  assign bus.busy_o     = (state_q == S_EXACT) || (state_q == S_COLOR) ||
                          (state_q == S_FINAL);
  assign bus.done_o     = done_q;
  assign bus.win_o      = win_q;
  assign bus.err_o      = err_q;
`ifdef MM_ATTEMPT_LIMIT_EN
  assign bus.attemptsLeft_o = attempts_q;
  assign bus.gameOver_o     = game_over;
`endif

endmodule : mastermind_score_ctrl
`default_nettype wire

// File: tb/tb_mastermind_score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_score_ctrl
//  Description : Self-checking bench for mastermind_score_ctrl with directed
//                and randomized scores against a matching-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mastermind_score_ctrl;
  localparam int NCOL    = 6;
  localparam int LATENCY = 5 + NCOL;

  logic clk   = 1'b0;
  logic Reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mastermind_score_ctrl_if bus ();

  mastermind_score_ctrl #(.NUM_COLORS(NCOL)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] pk(input int d3, input int d2, input int d1, input int d0);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  // Model: count position hits, then greedily pair each guess digit with an
  // unused equal secret digit; pairs beyond the exact hits are whites.
  function automatic void ref_score(input logic [11:0] g, input logic [11:0] s,
                                    output int ex, output int col, output bit inv);
    int  gd[4];
    int  sd[4];
    bit  used[4];
    int  total;
    ex = 0; total = 0; inv = 0;
    for (int i = 0; i < 4; i++) begin
      gd[i] = int'((g >> (3*i)) & 12'h7);
      sd[i] = int'((s >> (3*i)) & 12'h7);
      used[i] = 0;
      if (gd[i] >= NCOL || sd[i] >= NCOL) inv = 1;
      if (gd[i] == sd[i]) ex++;
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!used[j] && sd[j] == gd[i]) begin
          used[j] = 1;
          total++;
          break;
        end
      end
    end
    col = total - ex;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic maybe_reset();
`ifdef MM_ATTEMPT_LIMIT_EN
    if (bus.gameOver_o) do_reset();
`endif
  endtask

  task automatic expect_result(input string tag, input logic [11:0] g, input logic [11:0] s);
    int ex, col;
    bit inv;
    ref_score(g, s, ex, col, inv);
    chk({tag, "_exact"}, 32'(bus.exactNum_o), inv ? 32'h7 : 32'(ex));
    chk({tag, "_color"}, 32'(bus.colorNum_o), inv ? 32'h7 : 32'(col));
    chk({tag, "_win"},   32'(bus.win_o),      32'((!inv && ex == 4) ? 1 : 0));
    chk({tag, "_err"},   32'(bus.err_o),      32'(inv ? 1 : 0));
  endtask

  // Issue one start, check busy window, latency, one-cycle done and results
  task automatic run_score(input logic [11:0] g, input logic [11:0] s, input string tag);
    int lat = 0;
    bit busy_bad = 0;
    maybe_reset();
    bus.guess_i  = g;
    bus.secret_i = s;
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    while (!bus.done_o && lat < 40) begin
      if (bus.busy_o !== 1'b1) busy_bad = 1;
      bus.guess_i  = 12'($urandom);
      bus.secret_i = 12'($urandom);
      tick();
      lat++;
    end
    bus.guess_i  = g;
    bus.secret_i = s;
    chk({tag, "_latency"}, 32'(lat), 32'(LATENCY));
    chk({tag, "_busywin"}, 32'(busy_bad), 32'h0);
    chk({tag, "_busyfall"}, 32'(bus.busy_o), 32'h0);
    expect_result(tag, g, s);
    tick();
    chk({tag, "_donepulse"}, 32'(bus.done_o), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] g, s;
    int n_done;
    bit bad;
    bus.start_i  = 1'b0;
    bus.guess_i  = '0;
    bus.secret_i = '0;
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    repeat (3) tick();

    chk("rst_exact", 32'(bus.exactNum_o), 32'h7);
    chk("rst_color", 32'(bus.colorNum_o), 32'h7);
    chk("rst_busy",  32'(bus.busy_o), 32'h0);
    chk("rst_done",  32'(bus.done_o), 32'h0);
    chk("rst_win",   32'(bus.win_o), 32'h0);
    chk("rst_err",   32'(bus.err_o), 32'h0);

    // Directed scores from the plan, with hand-derived values as a cross-check
    run_score(pk(1,2,3,4), pk(1,2,3,4), "all_exact");
    chk("all_exact_hand", 32'({bus.exactNum_o, bus.colorNum_o, bus.win_o}), 32'({3'd4, 3'd0, 1'b1}));
    run_score(pk(4,3,2,1), pk(1,2,3,4), "all_color");
    chk("all_color_hand", 32'({bus.exactNum_o, bus.colorNum_o, bus.win_o}), 32'({3'd0, 3'd4, 1'b0}));
    run_score(pk(1,1,2,2), pk(1,2,3,4), "dup");
    chk("dup_hand", 32'({bus.exactNum_o, bus.colorNum_o}), 32'({3'd1, 3'd1}));
    run_score(pk(1,7,3,4), pk(1,2,3,4), "illegal");
    chk("illegal_hand", 32'({bus.exactNum_o, bus.colorNum_o, bus.err_o}), 32'({3'd7, 3'd7, 1'b1}));

    // Results from SHOW are held while a new score is in flight
    run_score(pk(4,3,2,1), pk(1,2,3,4), "pre_hold");
    maybe_reset();
    bus.guess_i  = pk(1,1,2,2);
    bus.secret_i = pk(1,2,3,4);
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    repeat (5) tick();
    chk("hold_busy",  32'(bus.busy_o), 32'h1);
    chk("hold_color", 32'(bus.colorNum_o), 32'h4);
    n_done = 0;
    while (!bus.done_o && n_done < 40) begin tick(); n_done++; end
    expect_result("after_hold", pk(1,1,2,2), pk(1,2,3,4));
    tick();

    // Randomized scores, occasionally with an illegal digit or a winning guess
    for (int t = 0; t < 24; t++) begin
      s = pk($urandom_range(0, NCOL-1), $urandom_range(0, NCOL-1),
             $urandom_range(0, NCOL-1), $urandom_range(0, NCOL-1));
      g = pk($urandom_range(0, NCOL-1), $urandom_range(0, NCOL-1),
             $urandom_range(0, NCOL-1), $urandom_range(0, NCOL-1));
      if ($urandom_range(0, 5) == 0) g = s;
      if ($urandom_range(0, 7) == 0) g[3*$urandom_range(0, 3) +: 3] = 3'($urandom_range(NCOL, 7));
      run_score(g, s, $sformatf("rnd%0d", t));
    end

    // A second start during busy is ignored; exactly one done follows
    maybe_reset();
    bus.guess_i  = pk(2,2,5,0);
    bus.secret_i = pk(0,2,5,3);
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    tick();
    tick();
    bus.guess_i  = pk(0,2,5,3);
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    bus.guess_i  = pk(5,5,5,5);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done_o) begin
        n_done++;
        expect_result("ign_start", pk(2,2,5,0), pk(0,2,5,3));
      end
      tick();
    end
    chk("ign_start_dones", 32'(n_done), 32'h1);

    // Reset mid-score aborts without a done pulse
    maybe_reset();
    bus.guess_i  = pk(3,1,4,1);
    bus.secret_i = pk(1,3,4,0);
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    repeat (5) tick();
    Reset = 1'b1;
    #1;
    chk("abort_exact", 32'(bus.exactNum_o), 32'h7);
    chk("abort_color", 32'(bus.colorNum_o), 32'h7);
    chk("abort_busy",  32'(bus.busy_o), 32'h0);
    tick();
    Reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done_o || bus.busy_o) n_done++;
      tick();
    end
    chk("abort_quiet", 32'(n_done), 32'h0);

`ifdef MM_ATTEMPT_LIMIT_EN
    do_reset();
    chk("att_reset", 32'(bus.attemptsLeft_o), 32'h4);
    for (int a = 0; a < 4; a++) begin
      run_score(pk(5,5,5,5), pk(1,2,3,4), $sformatf("att%0d", a));
      chk($sformatf("att%0d_left", a), 32'(bus.attemptsLeft_o), 32'(3 - a));
    end
    chk("att_gameover", 32'(bus.gameOver_o), 32'h1);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.busy_o || bus.done_o) bad = 1;
      tick();
    end
    chk("att_blocked", 32'(bad), 32'h0);
`else
    bad = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mastermind_score_ctrl
`default_nettype wire

// File: doc/mastermind_score_ctrl.md
Name: mastermind_score_ctrl

Overview:
- Sequential scoring controller for the Mastermind guess/secret comparison.
- On a start pulse it latches a 4-digit guess and a 4-digit secret, then walks positions and colours one per cycle.
- Produces exact-match (black) and colour-only (white) counts as 3-bit codes for the two side HEX display digit drivers, plus win/done/busy status.
- Sits between the game FSM (issues start) and the side display drivers (consume the counts).

Parameters:
- NUM_COLORS, 6, number of legal colours; legal digit values 0..NUM_COLORS-1; range 2..8.
- MAX_ATTEMPTS, 4, guesses allowed per game (optional feature only); range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to score the current guess.
- guess  in  12  digit i at bits [3i+2:3i], i=0..3.
- secret  in  12  same packing as guess.
- exactNum  out  3  black count 0..4, or 3'b111 (display off).
- colorNum  out  3  white count 0..4, or 3'b111 (display off).
- busy  out  1  high while scoring.
- done  out  1  one-cycle pulse when results update.
- win  out  1  high when last valid score had exactNum=4.
- err  out  1  high when last scored input held an illegal digit.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE, counters clear.
  - exactNum=colorNum=3'b111; busy=done=win=err=0.
- States: IDLE, EXACT, COLOR, FINAL, SHOW.
- IDLE/SHOW:
  - start=1 at edge k latches guess and secret into internal registers.
  - Computes inv = any latched digit >= NUM_COLORS.
  - Clears blackAcc, minAcc and idx; moves to EXACT.
  - Outputs keep their previous values until FINAL completes.
- EXACT, edges k+1..k+4:
  - At idx=0..3, blackAcc += (g[idx]==s[idx]).
  - After idx=3, goes to COLOR with idx=0.
- COLOR, edges k+5..k+4+NUM_COLORS:
  - For colour c=idx, counts occurrences in g and s (combinational over 4 digits).
  - minAcc += min(countG, countS).
  - After c=NUM_COLORS-1, goes to FINAL.
- FINAL, edge k+5+NUM_COLORS (k+11 at default):
  - If inv=0: exactNum=blackAcc, colorNum=minAcc-blackAcc, win=(blackAcc==4), err=0.
  - If inv=1: exactNum=colorNum=3'b111, win=0, err=1.
  - done=1 for exactly this one cycle; goes to SHOW.
- busy=1 in EXACT, COLOR and FINAL; otherwise 0. busy falls on the same edge that done rises.
- Widths:
  - blackAcc and minAcc are 3 bits; minAcc <= 4 always, and minAcc >= blackAcc always.
  - colorNum arithmetic is 3-bit unsigned with no wrap possible.
- start while busy=1 is ignored (not queued). guess/secret changes while busy have no effect.
- start in SHOW begins a new score immediately; the old results are held until the new FINAL.
- Duplicate colours are handled by the min-count rule, so each secret digit is credited at most once.
- Reset asserted mid-score aborts with no done pulse; outputs return to 3'b111.

Optional Feature:
- Macro MM_ATTEMPT_LIMIT_EN.
- Defined:
  - Adds output attemptsLeft [2:0], reset value MAX_ATTEMPTS, plus output gameOver.
  - Each FINAL with inv=0 decrements attemptsLeft (saturating at 0).
  - gameOver=1 when attemptsLeft==0 and win=0, or when win=1.
  - While gameOver=1, start is ignored until Reset.
  - attemptsLeft is 0..4 at default, so it can drive a third side display.
- Undefined: no extra ports; scoring is unlimited.

Test Plan:
- Reset then idle 3 cycles -> exactNum=colorNum=3'b111, busy=done=win=err=0.
- Secret digits (d3..d0) 1,2,3,4, guess 1,2,3,4, start at edge k -> busy high k+1..k+10; done pulse and exactNum=4, colorNum=0, win=1 at k+11.
- Same secret, guess 4,3,2,1 -> exactNum=0, colorNum=4, win=0. Then guess 1,1,2,2 -> exactNum=1, colorNum=1 (duplicate rule).
- Guess digit d2=7 (illegal), secret 1,2,3,4 -> done at k+11; exactNum=colorNum=3'b111, err=1, win=0.
- Reset pulsed at k+6 mid-score -> immediate IDLE, outputs 3'b111, no done. Separately, a second start at k+3 is ignored and exactly one done occurs.
- With MM_ATTEMPT_LIMIT_EN: four wrong guesses -> attemptsLeft 3,2,1,0, gameOver=1; a fifth start produces no busy and no done.
